// File: rtl/matrix_transmitter.sv
// matrix_transmitter: sending end of the 2x4 cell matrix UART link.
// Holds a 2x4 matrix of W-bit cells and serialises one cell, a row, a column
// or the whole matrix as a single frame: start 0, data LSB first per cell,
// optional parity over every data bit of the frame, stop 1.
module matrix_transmitter #(
  parameter int W   = 8,
  parameter int DIV = 3,
  parameter int PAR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         row,
  input  logic [1:0]   col,
  input  logic [3:0]   action,
  input  logic [W-1:0] w_data,
  output logic         tx,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r_cell
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  // Matrix address {row, col} of the idx-th cell of a frame for a given mode.
  function automatic logic [2:0] cell_addr(input logic [2:0] mode,
                                           input logic       r,
                                           input logic [1:0] c,
                                           input logic [2:0] idx);
    logic [2:0] a;
    case (mode)
      3'd2:    a = {r, c};
      3'd3:    a = {r, idx[1:0]};
      3'd4:    a = {idx[0], c};
      3'd5:    a = idx;
      default: a = {r, c};
    endcase
    return a;
  endfunction

  // Index of the final cell of a frame (cell count minus one).
  function automatic logic [2:0] last_idx(input logic [2:0] mode);
    logic [2:0] n;
    case (mode)
      3'd2:    n = 3'd0;
      3'd3:    n = 3'd3;
      3'd4:    n = 3'd1;
      3'd5:    n = 3'd7;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  logic [W-1:0]  mem_q [0:7];
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [2:0]    cell_q, cell_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    mode_q, mode_d;
  logic          lrow_q, lrow_d;
  logic [1:0]    lcol_q, lcol_d;

  logic          accept_s;
  logic          write_s;
  logic [BW-1:0] nbit_s;
  logic [2:0]    ncell_s;
  logic          dbit_s;

  assign accept_s = !busy_q && (action >= 4'd2) && (action <= 4'd5);
  assign write_s  = !busy_q && (action == 4'd1);

  assign tx     = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign r_cell = mem_q[{row, col}];

  // Next data position (bit, cell) and the bit stored there.
  always_comb begin
    if (state_q == S_START) begin
      nbit_s  = {BW{1'b0}};
      ncell_s = 3'd0;
    end else if (bit_q == BIT_LAST) begin
      nbit_s  = {BW{1'b0}};
      ncell_s = cell_q + 3'd1;
    end else begin
      nbit_s  = bit_q + {{(BW-1){1'b0}}, 1'b1};
      ncell_s = cell_q;
    end
    dbit_s = mem_q[cell_addr(mode_q, lrow_q, lcol_q, ncell_s)][nbit_s];
  end

  // Frame sequencer: accept, bit timing, data stepping, parity and stop.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cell_d  = cell_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    lrow_d  = lrow_q;
    lcol_d  = lcol_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_START;
          div_d   = {DW{1'b0}};
          bit_d   = {BW{1'b0}};
          cell_d  = 3'd0;
          par_d   = 1'b0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          mode_d  = action[2:0];
          lrow_d  = row;
          lcol_d  = col;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + {{(DW-1){1'b0}}, 1'b1};
        end else begin
          div_d = {DW{1'b0}};
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              bit_d   = nbit_s;
              cell_d  = ncell_s;
              tx_d    = dbit_s;
              par_d   = par_q ^ dbit_s;
            end
            S_DATA: begin
              if ((bit_q == BIT_LAST) && (cell_q == last_idx(mode_q))) begin
                if (PAR != 0) begin
                  state_d = S_PARITY;
                  tx_d    = (PAR == 2) ? ~par_q : par_q;
                end else begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
                end
              end else begin
                bit_d  = nbit_s;
                cell_d = ncell_s;
                tx_d   = dbit_s;
                par_d  = par_q ^ dbit_s;
              end
            end
            S_PARITY: begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
            S_STOP: begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset forces an idle line immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= {DW{1'b0}};
      bit_q   <= {BW{1'b0}};
      cell_q  <= 3'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 3'd0;
      lrow_q  <= 1'b0;
      lcol_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cell_q  <= cell_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      lrow_q  <= lrow_d;
      lcol_q  <= lcol_d;
    end
  end

  // Cell storage: writes only while idle, so contents are frozen mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (write_s) begin
      mem_q[{row, col}] <= w_data;
    end
  end

endmodule

// File: tb/tb_matrix_transmitter.sv
// Bench for matrix_transmitter: one instance with DIV=3/even parity (A) and
// one with DIV=1/no parity (B), checked bit by bit against a frame model.
module tb_matrix_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, row_a, tx_a, busy_a, done_a;
  logic [1:0] col_a;
  logic [3:0] act_a;
  logic [7:0] wd_a, rc_a;
  logic       rst_b, row_b, tx_b, busy_b, done_b;
  logic [1:0] col_b;
  logic [3:0] act_b;
  logic [7:0] wd_b, rc_b;

  matrix_transmitter #(.W(8), .DIV(3), .PAR(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .row(row_a), .col(col_a), .action(act_a),
    .w_data(wd_a), .tx(tx_a), .busy(busy_a), .done(done_a), .r_cell(rc_a));

  matrix_transmitter #(.W(8), .DIV(1), .PAR(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .row(row_b), .col(col_b), .action(act_b),
    .w_data(wd_b), .tx(tx_b), .busy(busy_b), .done(done_b), .r_cell(rc_b));

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] mdl [0:1][0:7];
  bit         exp_q [$];
  int         blen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic [3:0] a, input logic r,
                        input logic [1:0] c, input logic [7:0] d);
    if (w == 0) begin act_a = a; row_a = r; col_a = c; wd_a = d; end
    else        begin act_b = a; row_b = r; col_b = c; wd_b = d; end
  endtask

  function automatic logic o_tx(input int w);   return (w == 0) ? tx_a   : tx_b;   endfunction
  function automatic logic o_busy(input int w); return (w == 0) ? busy_a : busy_b; endfunction
  function automatic logic o_done(input int w); return (w == 0) ? done_a : done_b; endfunction
  function automatic logic [7:0] o_rc(input int w); return (w == 0) ? rc_a : rc_b; endfunction

  task automatic do_write(input int w, input logic r, input logic [1:0] c, input logic [7:0] d);
    set_in(w, 4'd1, r, c, d);
    tick();
    mdl[w][{r, c}] = d;
    chk("write_readback", {24'd0, o_rc(w)}, {24'd0, d});
    set_in(w, 4'd0, r, c, 8'd0);
  endtask

  task automatic check_all_cells(input int w, input string tag);
    for (int a = 0; a < 8; a++) begin
      set_in(w, 4'd0, a[2], a[1:0], 8'd0);
      #1;
      chk(tag, {24'd0, o_rc(w)}, {24'd0, mdl[w][a]});
    end
  endtask

  // Expected line bits of a frame, built from the cell list the command names.
  task automatic build_frame(input int w, input logic [3:0] act, input logic r, input logic [1:0] c);
    int  cells [$];
    bit  p;
    cells.delete();
    exp_q.delete();
    case (act)
      4'd2: cells.push_back(r * 4 + c);
      4'd3: for (int i = 0; i < 4; i++) cells.push_back(r * 4 + i);
      4'd4: begin cells.push_back(c); cells.push_back(4 + c); end
      default: for (int i = 0; i < 8; i++) cells.push_back(i);
    endcase
    p = 1'b0;
    exp_q.push_back(1'b0);
    foreach (cells[k]) begin
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(mdl[w][cells[k]][b]);
        p ^= mdl[w][cells[k]][b];
      end
    end
    if (w == 0) exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  // Send one frame and check every cycle. junk: 0 idle inputs, 1 random
  // commands during the frame, 2 a write to [0][0] and a row send mid-frame.
  task automatic run_frame(input int w, input logic [3:0] act, input logic r,
                           input logic [1:0] c, input int junk, output int busy_cnt);
    int div;
    int cyc;
    div = (w == 0) ? 3 : 1;
    build_frame(w, act, r, c);
    set_in(w, act, r, c, 8'($urandom));
    busy_cnt = 0;
    cyc = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int k = 0; k < div; k++) begin
        tick();
        cyc++;
        if (junk == 1)
          set_in(w, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 8'($urandom));
        else if (junk == 2 && cyc == 5)
          set_in(w, 4'd1, 1'b0, 2'd0, 8'hFF);
        else if (junk == 2 && cyc == 10)
          set_in(w, 4'd3, 1'b1, 2'd1, 8'h00);
        else
          set_in(w, 4'd0, r, c, 8'h00);
        if (o_busy(w) === 1'b1) busy_cnt++;
        chk($sformatf("tx_bit%0d", i), {31'd0, o_tx(w)}, {31'd0, exp_q[i]});
        chk("busy_in_frame", {31'd0, o_busy(w)}, 32'd1);
        chk("done_in_frame", {31'd0, o_done(w)}, 32'd0);
      end
    end
    tick();
    chk("end_busy", {31'd0, o_busy(w)}, 32'd0);
    chk("end_done", {31'd0, o_done(w)}, 32'd1);
    chk("end_tx",   {31'd0, o_tx(w)},   32'd1);
    set_in(w, 4'd0, r, c, 8'h00);
  endtask

  task automatic idle_after(input int w, input string tag);
    tick();
    chk({tag, "_busy"}, {31'd0, o_busy(w)}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done(w)}, 32'd0);
    chk({tag, "_tx"},   {31'd0, o_tx(w)},   32'd1);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    set_in(0, 4'd0, 1'b0, 2'd0, 8'd0);
    set_in(1, 4'd0, 1'b0, 2'd0, 8'd0);
    for (int a = 0; a < 8; a++) begin mdl[0][a] = 8'd0; mdl[1][a] = 8'd0; end

    // 1. reset state
    #2;
    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    for (int w = 0; w < 2; w++) begin
      chk("rst_tx",   {31'd0, o_tx(w)},   32'd1);
      chk("rst_busy", {31'd0, o_busy(w)}, 32'd0);
      chk("rst_done", {31'd0, o_done(w)}, 32'd0);
      check_all_cells(w, "rst_rcell");
    end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // 2. single cell
    do_write(0, 1'b0, 2'd2, 8'hA5);
    run_frame(0, 4'd2, 1'b0, 2'd2, 0, blen);
    chk("t2_busy_len", blen, 32'd33);
    idle_after(0, "t2_after");

    // 3 + 4. whole matrix, with a write and row send issued mid-frame
    for (int a = 0; a < 8; a++) do_write(0, a[2], a[1:0], 8'(a + 1));
    run_frame(0, 4'd5, 1'b0, 2'd0, 2, blen);
    chk("t3_busy_len", blen, 32'd201);
    idle_after(0, "t4_no_second");
    set_in(0, 4'd0, 1'b0, 2'd0, 8'd0);
    #1;
    chk("t4_cell00", {24'd0, rc_a}, 32'h01);

    // 5. async reset during data bit 4
    set_in(0, 4'd5, 1'b0, 2'd0, 8'd0);
    tick();
    set_in(0, 4'd0, 1'b0, 2'd0, 8'd0);
    repeat (15) tick();
    chk("t5_busy_before", {31'd0, busy_a}, 32'd1);
    #2;
    rst_a = 1'b1;
    #1;
    chk("t5_tx_async",   {31'd0, tx_a},   32'd1);
    chk("t5_busy_async", {31'd0, busy_a}, 32'd0);
    chk("t5_done_async", {31'd0, done_a}, 32'd0);
    #2;
    rst_a = 1'b0;
    for (int a = 0; a < 8; a++) mdl[0][a] = 8'd0;
    check_all_cells(0, "t5_cleared");
    idle_after(0, "t5_after");

    // 6. column send on the DIV=1, no-parity instance, then back-to-back
    do_write(1, 1'b0, 2'd3, 8'h3C);
    do_write(1, 1'b1, 2'd3, 8'hC3);
    run_frame(1, 4'd4, 1'b0, 2'd3, 0, blen);
    chk("t6_busy_len", blen, 32'd18);
    run_frame(1, 4'd2, 1'b1, 2'd3, 0, blen);
    chk("t6_b2b_len", blen, 32'd10);
    idle_after(1, "t6_after");

    // Randomized commands on both instances
    for (int it = 0; it < 24; it++) begin
      int w;
      int kind;
      logic r;
      logic [1:0] c;
      w = it % 2;
      kind = $urandom_range(0, 4);
      r = 1'($urandom_range(0, 1));
      c = 2'($urandom_range(0, 3));
      if (kind <= 1) begin
        do_write(w, r, c, 8'($urandom));
        do_write(w, ~r, c + 2'd1, 8'($urandom));
      end else if (kind == 2) begin
        set_in(w, (($urandom_range(0, 1)) != 0) ? 4'd0 : 4'($urandom_range(6, 15)), r, c, 8'($urandom));
        idle_after(w, "rnd_noop");
      end else begin
        logic [3:0] a;
        a = 4'($urandom_range(2, 5));
        run_frame(w, a, r, c, 1, blen);
        chk("rnd_busy_len", blen, exp_q.size() * ((w == 0) ? 3 : 1));
        idle_after(w, "rnd_after");
        check_all_cells(w, "rnd_frozen");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_transmitter.md
# matrix_transmitter

Serial transmitter for the 2x4 cell matrix link: holds a local 2x4 matrix of W-bit cells and serialises a single cell, a row, a column or the whole matrix onto `tx` as one frame. A frame is a start bit, the data bits, an optional parity bit and a stop bit. It is the sending end of the matrix UART link and uses the same action codes, cell ordering, bit ordering and parity convention as the matrix receiver.

## Interface
- `W`, 8, cell width in bits.
- `DIV`, 3, clocks per serial bit (≥1).
- `PAR`, 0, parity mode: 0 none, 1 even (bit = XOR of all data bits), 2 odd (bit = inverted XOR).

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `row`  in  1  matrix row select.
- `col`  in  2  matrix column select.
- `action`  in  4  command: 1 write cell, 2 send cell, 3 send row, 4 send column, 5 send matrix; others no-op.
- `w_data`  in  W  write data for action 1.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at end of frame.
- `r_cell`  out  W  combinational readback of `matrix[row][col]`.

## Operation
- Commands are sampled on each rising `clk` edge where `busy`=0. While `busy`=1, every action is ignored, including writes. Matrix contents are therefore frozen during a frame.
- Action 1 sets `matrix[row][col] <= w_data`. `busy` stays 0.
- Actions 2–5 latch the cell set at the accept edge. Later changes to `row`/`col` have no effect until the next frame.
  - 2: the single cell `[row][col]`.
  - 3: `[row][0..3]`.
  - 4: `[0][col]`, then `[1][col]`.
  - 5: all cells in row-major order, `[0][0]..[0][3]` then `[1][0]..[1][3]`.
- Frame contents, in order:
  - start bit 0;
  - for each cell in order, W data bits, LSB first;
  - if PAR≠0, one parity bit computed over all data bits of the frame (not per cell);
  - stop bit 1.
- Frame length in bits is 1 + N·W + (PAR≠0) + 1, where N = 1, 4, 2 or 8 for actions 2, 3, 4, 5.
- State machine: IDLE → START → DATA → (PARITY if PAR≠0) → STOP → IDLE.
  - Each state holds for DIV clocks per bit.
  - DATA steps through the bit index 0..W-1, then advances to the next cell.
- Counters:
  - divider counts 0..DIV-1;
  - bit index counts 0..W-1;
  - cell index counts 0..N-1.
  - The parity accumulator is cleared at accept and XORs in each data bit as it is driven.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, all matrix cells 0, so `r_cell`=0. State is IDLE.
- Reset mid-frame: `tx` returns to 1 and `busy`/`done` to 0 immediately, without waiting for a clock. The frame is abandoned and the matrix is cleared.
- Accept edge E (`busy`=0 and action in 2..5): at E, `busy` <= 1 and `tx` <= 0. The start bit is held for the DIV cycles following E.
- Each subsequent bit begins exactly DIV cycles after the previous one. `tx` is registered and glitch-free.
- Total busy time is exactly (frame bits)·DIV cycles.
- Edge at which the stop bit's DIV cycles complete:
  - `busy` <= 0 and `done` <= 1 for that one cycle;
  - `tx` stays 1.
- A command presented on that same edge is ignored, because `busy` was still 1. The earliest next accept is the following edge.
- Write latency: a write accepted at edge E is visible on `r_cell` after E.
- Back-to-back: a new frame's start bit follows the previous stop bit with at least one idle cycle of `tx`=1.

## Test plan
1. Reset, parameters W=8, DIV=3, PAR=1: assert `rst` → `tx`=1, `busy`=0, `done`=0, and `r_cell`=0 for all 8 addresses.
2. Send one cell:
   - Stimulus: write 0xA5 to [0][2], then action 2 with row=0, col=2.
   - `tx` per 3-cycle bit: 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1.
   - `busy` is high for 33 cycles, then `done` pulses once.
3. Send whole matrix:
   - Stimulus: write 0x01..0x08 to [0][0]..[1][3], then action 5.
   - 64 data bits appear in row-major order, LSB first.
   - Parity bit is 1 (13 ones in total). `busy` lasts 201 cycles.
4. Ignore while busy:
   - Stimulus: during test 3, issue action 1 writing 0xFF to [0][0], and issue action 3.
   - Required: frame bits are unchanged, `r_cell[0][0]` still reads 0x01, and no second frame starts.
5. Async reset mid-frame: assert `rst` between clock edges during data bit 4 → `tx`=1 and `busy`=0 before the next edge. After release, `r_cell` reads 0 everywhere.
6. Column send, DIV=1, PAR=0:
   - Stimulus: cells [0][3]=0x3C, [1][3]=0xC3; action 4 with col=3.
   - Required: 18-cycle frame of 0, 0x3C bits LSB first, 0xC3 bits LSB first, then 1. No parity bit.
   - `done` pulses on cycle 18. A new action 2 issued one cycle later is accepted.
